// File: rtl/bp_pkg.sv
// Shared definitions for the branch predictor: counter encodings and
// the constants used at reset and on allocation.
package bp_pkg;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } ctr_t;

    // Freshly reset entries lean not-taken; new allocations lean taken
    // because they are only created by a taken branch.
    localparam ctr_t CTR_RESET = WNT;
    localparam ctr_t CTR_ALLOC = WT;

    localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;

    // Statistics counters stick at all-ones instead of wrapping.
    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == CNT_MAX) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/branch_predictor_sat_counter2.sv
// Next-state logic for a 2-bit saturating taken/not-taken counter.
module sat_counter2
    import bp_pkg::*;
(
    input  ctr_t i_ctr,
    input  logic i_taken,
    output ctr_t o_ctr
);

    // Step toward ST on taken, toward SNT on not-taken, holding at the ends.
    always_comb begin
        o_ctr = i_ctr;
        case (i_ctr)
            SNT: o_ctr = i_taken ? WNT : SNT;
            WNT: o_ctr = i_taken ? WT  : SNT;
            WT:  o_ctr = i_taken ? ST  : WNT;
            ST:  o_ctr = i_taken ? ST  : WT;
            default: o_ctr = i_ctr;
        endcase
    end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped branch target buffer with 2-bit counters. Lookup is
// purely combinational; updates from the execute stage land on the clock
// edge and are visible to lookup from the following cycle.
module branch_predictor
    import bp_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int ENTRIES = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] if_pc,
    output logic            pred_taken,
    output logic [XLEN-1:0] pred_next_pc,
    input  logic            upd_valid,
    input  logic [XLEN-1:0] upd_pc,
    input  logic            upd_taken,
    input  logic [XLEN-1:0] upd_target,
    input  logic            upd_mispredict,
    output logic [31:0]     branch_cnt,
    output logic [31:0]     mispredict_cnt
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = XLEN - 2 - IDX_W;

    // Flattened views of per-entry state so both ports can index them.
    logic [ENTRIES-1:0] w_valid;
    ctr_t               w_ctr    [ENTRIES];
    logic [TAG_W-1:0]   w_tag    [ENTRIES];
    logic [XLEN-1:0]    w_target [ENTRIES];

    logic [IDX_W-1:0] w_if_idx;
    logic [TAG_W-1:0] w_if_tag;
    logic             w_if_hit;
    logic [IDX_W-1:0] w_upd_idx;
    logic [TAG_W-1:0] w_upd_tag;
    logic             w_upd_hit;
    ctr_t             w_ctr_next;
    logic             w_unused_pc_bits;

    logic [31:0] r_branch_cnt;
    logic [31:0] r_mispredict_cnt;

    // Byte offset within the word never selects a different branch.
    assign w_unused_pc_bits = ^{upd_pc[1:0], if_pc[1:0]};

    // Fetch-side lookup, no bypass from a concurrent update.
    assign w_if_idx     = if_pc[IDX_W+1:2];
    assign w_if_tag     = if_pc[XLEN-1:IDX_W+2];
    assign w_if_hit     = w_valid[w_if_idx] && (w_tag[w_if_idx] == w_if_tag);
    assign pred_taken   = w_if_hit && w_ctr[w_if_idx][1];
    assign pred_next_pc = pred_taken ? w_target[w_if_idx] : if_pc + XLEN'(4);

    // Execute-side lookup that decides between training and allocating.
    assign w_upd_idx = upd_pc[IDX_W+1:2];
    assign w_upd_tag = upd_pc[XLEN-1:IDX_W+2];
    assign w_upd_hit = w_valid[w_upd_idx] && (w_tag[w_upd_idx] == w_upd_tag);

    sat_counter2 u_sat_counter2 (
        .i_ctr   (w_ctr[w_upd_idx]),
        .i_taken (upd_taken),
        .o_ctr   (w_ctr_next)
    );

    generate
        for (genvar gi = 0; gi < ENTRIES; gi++) begin : gen_entry
            logic             r_valid;
            ctr_t             r_ctr;
            logic [TAG_W-1:0] r_tag;
            logic [XLEN-1:0]  r_target;
            logic             w_sel;

            assign w_sel = upd_valid && (w_upd_idx == IDX_W'(gi));

            // Valid and counter: cleared by reset, trained on hit, seeded on taken miss.
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_valid <= 1'b0;
                    r_ctr   <= CTR_RESET;
                end else if (w_sel) begin
                    if (w_upd_hit) begin
                        r_ctr <= w_ctr_next;
                    end else if (upd_taken) begin
                        r_valid <= 1'b1;
                        r_ctr   <= CTR_ALLOC;
                    end
                end
            end

            // Tag and target carry no reset; only taken outcomes write them.
            always_ff @(posedge clk) begin
                if (!rst && w_sel && upd_taken) begin
                    r_target <= upd_target;
                    if (!w_upd_hit) begin
                        r_tag <= w_upd_tag;
                    end
                end
            end

            assign w_valid[gi]  = r_valid;
            assign w_ctr[gi]    = r_ctr;
            assign w_tag[gi]    = r_tag;
            assign w_target[gi] = r_target;
        end
    endgenerate

    // Saturating statistics of resolved branches and mispredictions.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_branch_cnt     <= '0;
            r_mispredict_cnt <= '0;
        end else if (upd_valid) begin
            r_branch_cnt <= sat_inc32(r_branch_cnt);
            if (upd_mispredict) begin
                r_mispredict_cnt <= sat_inc32(r_mispredict_cnt);
            end
        end
    end

    assign branch_cnt     = r_branch_cnt;
    assign mispredict_cnt = r_mispredict_cnt;

endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboard bench for branch_predictor: each stimulus cycle queues the
// expected lookup result and counter values; a negedge monitor pops and compares.
module tb_branch_predictor;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] if_pc;
    logic        pred_taken;
    logic [31:0] pred_next_pc;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic        upd_mispredict;
    logic [31:0] branch_cnt;
    logic [31:0] mispredict_cnt;

    typedef struct {
        logic        taken;
        logic [31:0] next_pc;
        logic [31:0] bcnt;
        logic [31:0] mcnt;
        int          id;
    } exp_t;

    exp_t        sb_q[$];
    logic        mon_req = 1'b0;
    int          checks = 0;
    int          errors = 0;
    int          step_id = 0;
    logic [31:0] exp_b = 32'd0;
    logic [31:0] exp_m = 32'd0;

    branch_predictor #(.XLEN(32), .ENTRIES(16)) dut (
        .clk            (clk),
        .rst            (rst),
        .if_pc          (if_pc),
        .pred_taken     (pred_taken),
        .pred_next_pc   (pred_next_pc),
        .upd_valid      (upd_valid),
        .upd_pc         (upd_pc),
        .upd_taken      (upd_taken),
        .upd_target     (upd_target),
        .upd_mispredict (upd_mispredict),
        .branch_cnt     (branch_cnt),
        .mispredict_cnt (mispredict_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int id, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s step %0d: got 0x%08h expected 0x%08h", name, id, act, req);
        end
    endtask

    // Monitor: the DUT presents a lookup result every cycle the stimulus flags.
    always @(negedge clk) begin
        if (mon_req) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_empty: got no expected entry, required one");
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("pred_taken", e.id, {31'd0, pred_taken}, {31'd0, e.taken});
                chk("pred_next_pc", e.id, pred_next_pc, e.next_pc);
                chk("branch_cnt", e.id, branch_cnt, e.bcnt);
                chk("mispredict_cnt", e.id, mispredict_cnt, e.mcnt);
                $display("step %0d pc=0x%08h taken=%0b next=0x%08h bcnt=0x%08h mcnt=0x%08h",
                         e.id, if_pc, pred_taken, pred_next_pc, branch_cnt, mispredict_cnt);
            end
        end
    end

    // One cycle: drive lookup and update, queue the pre-edge expectation.
    task automatic cyc(input logic [31:0] pc, input logic uv, input logic [31:0] upc,
                       input logic ut, input logic [31:0] utgt, input logic umis,
                       input logic et, input logic [31:0] en);
        exp_t e;
        if_pc          = pc;
        upd_valid      = uv;
        upd_pc         = upc;
        upd_taken      = ut;
        upd_target     = utgt;
        upd_mispredict = umis;
        e.taken   = et;
        e.next_pc = en;
        e.bcnt    = exp_b;
        e.mcnt    = exp_m;
        e.id      = step_id;
        step_id++;
        sb_q.push_back(e);
        mon_req = 1'b1;
        @(posedge clk);
        #1;
        mon_req = 1'b0;
        if (uv) begin
            if (exp_b != 32'hFFFF_FFFF) exp_b = exp_b + 32'd1;
            if (umis && exp_m != 32'hFFFF_FFFF) exp_m = exp_m + 32'd1;
        end
    endtask

    task automatic look(input logic [31:0] pc, input logic et, input logic [31:0] en);
        cyc(pc, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, et, en);
    endtask

    // Reset for one edge, optionally with a competing update.
    task automatic do_reset(input logic uv);
        rst            = 1'b1;
        upd_valid      = uv;
        upd_pc         = 32'h0000_0104;
        upd_taken      = 1'b1;
        upd_target     = 32'h0000_0700;
        upd_mispredict = 1'b1;
        @(posedge clk);
        #1;
        rst       = 1'b0;
        upd_valid = 1'b0;
        exp_b     = 32'd0;
        exp_m     = 32'd0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        if_pc = 32'h0; upd_valid = 1'b0; upd_pc = 32'h0;
        upd_taken = 1'b0; upd_target = 32'h0; upd_mispredict = 1'b0;
        @(posedge clk);
        #1;
        do_reset(1'b0);

        // Reset state, then first allocation (checked pre-update).
        look(32'h100, 1'b0, 32'h104);
        cyc (32'h100, 1'b1, 32'h100, 1'b1, 32'h80, 1'b1, 1'b0, 32'h104);
        look(32'h100, 1'b1, 32'h80);

        // Training up to strongly taken, then back down.
        for (int i = 0; i < 4; i++)
            cyc(32'h100, 1'b1, 32'h100, 1'b1, 32'h80, 1'b0, 1'b1, 32'h80);
        cyc (32'h100, 1'b1, 32'h100, 1'b0, 32'h0, 1'b1, 1'b1, 32'h80);
        cyc (32'h100, 1'b1, 32'h100, 1'b0, 32'h0, 1'b1, 1'b1, 32'h80);
        look(32'h100, 1'b0, 32'h104);

        // Same index, different tag replaces the occupant.
        cyc (32'h140, 1'b1, 32'h140, 1'b1, 32'h300, 1'b0, 1'b0, 32'h144);
        look(32'h100, 1'b0, 32'h104);
        look(32'h140, 1'b1, 32'h300);

        // Not-taken miss leaves the table alone; taken hit rewrites target.
        cyc (32'h140, 1'b1, 32'h180, 1'b0, 32'h0, 1'b0, 1'b1, 32'h300);
        cyc (32'h140, 1'b1, 32'h140, 1'b1, 32'h400, 1'b1, 1'b1, 32'h300);
        look(32'h143, 1'b1, 32'h400);

        // Update inputs ignored without upd_valid.
        cyc (32'h140, 1'b0, 32'h140, 1'b1, 32'h999, 1'b1, 1'b1, 32'h400);
        look(32'h140, 1'b1, 32'h400);
        look(32'h7, 1'b0, 32'hB);
        look(32'hFFFF_FFFC, 1'b0, 32'h0);

        // Same-cycle lookup of a fresh allocation sees the old state.
        cyc (32'h200, 1'b1, 32'h200, 1'b1, 32'h500, 1'b0, 1'b0, 32'h204);
        cyc (32'h200, 1'b1, 32'h104, 1'b1, 32'h600, 1'b0, 1'b1, 32'h500);
        look(32'h104, 1'b1, 32'h600);

        // Reset wins over a simultaneous update.
        do_reset(1'b1);
        look(32'h200, 1'b0, 32'h204);
        look(32'h104, 1'b0, 32'h108);

        // Counter saturation from a preloaded near-max value.
        force dut.r_branch_cnt = 32'hFFFF_FFFE;
        force dut.r_mispredict_cnt = 32'hFFFF_FFFE;
        #1;
        release dut.r_branch_cnt;
        release dut.r_mispredict_cnt;
        exp_b = 32'hFFFF_FFFE;
        exp_m = 32'hFFFF_FFFE;
        for (int i = 0; i < 3; i++)
            cyc(32'h300, 1'b1, 32'h3C0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h304);
        look(32'h300, 1'b0, 32'h304);

        for (int i = 0; i < 10 && sb_q.size() != 0; i++) @(negedge clk);
        if (sb_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL sb_drain: got %0d entries left, required 0", sb_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/branch_predictor.md
BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 The module SHALL have parameter XLEN, default 32, meaning the address/data width.
REQ-002 The module SHALL have parameter ENTRIES, default 16, meaning the number of predictor entries; it SHALL be a power of two and at least 2.
REQ-003 The module SHALL derive IDX_W = log2(ENTRIES) and TAG_W = XLEN-2-IDX_W as localparams.
REQ-004 Port clk  input  1  the single clock; all state updates on its rising edge.
REQ-005 Port rst  input  1  reset; one clock, synchronous, active-high.
REQ-006 Port if_pc  input  XLEN  fetch-stage PC to predict.
REQ-007 Port pred_taken  output  1  1 = predicted taken for if_pc.
REQ-008 Port pred_next_pc  output  XLEN  predicted next fetch PC.
REQ-009 Port upd_valid  input  1  an EX-stage branch/jump resolves this cycle.
REQ-010 Port upd_pc  input  XLEN  PC of the resolved instruction.
REQ-011 Port upd_taken  input  1  actual outcome.
REQ-012 Port upd_target  input  XLEN  actual taken target.
REQ-013 Port upd_mispredict  input  1  pipeline detected a wrong prediction; qualified by upd_valid.
REQ-014 Port branch_cnt  output  32  resolved-branch count.
REQ-015 Port mispredict_cnt  output  32  misprediction count.

Function
REQ-016 Each entry SHALL hold valid (1b), tag (TAG_W), target (XLEN), and a 2-bit saturating counter.
REQ-017 Index SHALL be pc[IDX_W+1:2]; tag SHALL be pc[XLEN-1:IDX_W+2]; pc[1:0] SHALL be ignored.
REQ-018 Lookup SHALL be combinational (zero latency): hit = valid && tag match at index(if_pc).
REQ-019 pred_taken SHALL be hit && ctr[1].
REQ-020 pred_next_pc SHALL be target when pred_taken, else if_pc+4, with the sum wrapping modulo 2^XLEN.
REQ-021 On a clock edge with upd_valid=1 and an update hit, the counter SHALL increment (saturating at 11) if upd_taken, else decrement (saturating at 00).
REQ-022 On an update hit with upd_taken=1, target SHALL be overwritten with upd_target.
REQ-023 On an update miss with upd_taken=1, the entry SHALL be allocated: valid=1, tag written, target=upd_target, ctr=10 (weakly taken); any previous occupant SHALL be replaced.
REQ-024 On an update miss with upd_taken=0, the table SHALL be left unchanged.
REQ-025 Updates SHALL become visible to lookup on the cycle after the update edge; a same-cycle lookup of the same index SHALL return pre-update state (no bypass).
REQ-026 branch_cnt SHALL increment on each edge with upd_valid=1 and SHALL saturate at 32'hFFFF_FFFF.
REQ-027 mispredict_cnt SHALL increment on each edge with upd_valid && upd_mispredict and SHALL saturate at 32'hFFFF_FFFF.
REQ-028 With upd_valid=0, upd_* inputs SHALL be ignored.

Reset
REQ-029 With rst=1 at an edge, all valid bits SHALL clear, all counters SHALL become 01, and branch_cnt and mispredict_cnt SHALL become 0.
REQ-030 Reset SHALL override a simultaneous update.
REQ-031 After reset, pred_taken=0 and pred_next_pc=if_pc+4 for every if_pc.
REQ-032 Tag and target contents SHALL need no reset.

Structure
REQ-033 Package bp_pkg SHALL hold the counter encodings SNT=00, WNT=01, WT=10, ST=11 and the reset/allocate constants.
REQ-034 The 2-bit saturating next-state logic SHALL be a sub-module named sat_counter2.

Verification
REQ-035 Scenario: reset, then if_pc=0x100 -> pred_taken=0, pred_next_pc=0x104; both counters 0.
REQ-036 Scenario: update pc=0x100, taken, target 0x80 -> next cycle pred_taken=1, pred_next_pc=0x80, ctr=10.
REQ-037 Scenario: four consecutive taken updates at 0x100 -> ctr=11; then one not-taken -> ctr=10, still predicts taken; second not-taken -> ctr=01, pred_next_pc=0x104.
REQ-038 Scenario (ENTRIES=16): allocate 0x100, then taken update at 0x140 (same index, different tag) -> lookup 0x100 misses (0x104), lookup 0x140 hits.
REQ-039 Scenario: same-cycle lookup and first allocate of 0x200 -> that cycle pred_next_pc=0x204, next cycle equals the new target; rst asserted with upd_valid -> table and counters cleared.
REQ-040 Scenario: preload branch_cnt to 32'hFFFF_FFFF via forced update stream -> further updates leave branch_cnt=32'hFFFF_FFFF.
